// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Issue/writeback stage. Decodes an instruction, drives the ALU for one
//          execute cycle, writes the result back and reports it downstream.
// Rev    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] REG_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [3:0]        alu_component_select,
  output logic [DATA_W-1:0] alu_input_1,
  output logic [DATA_W-1:0] alu_input_2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_rd,
  output logic              out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_OP_LDI   = 3'b101;
  localparam logic [2:0] c_OP_ILL   = 3'b110;
  localparam logic [3:0] c_SEL_PASS = 4'b0111;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_regs [4];
  logic [1:0]        r_rd;
  logic              r_illegal;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_rd;
  logic              r_out_err;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;

  logic [2:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs1;
  logic [1:0]        w_rs2;
  logic [7:0]        w_imm;
  logic              w_accept;
  logic              w_deliver;

  // rs2 and imm8 overlap at bit 7; which one matters depends on the opcode
  assign w_op      = in_instr[15:13];
  assign w_rd      = in_instr[12:11];
  assign w_rs1     = in_instr[10:9];
  assign w_rs2     = in_instr[8:7];
  assign w_imm     = in_instr[7:0];
  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (w_deliver) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= REG_RESET;
      r_rd        <= '0;
      r_illegal   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_err   <= 1'b0;
      r_sel       <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
    end else begin
      // Ready is registered, so it first rises one cycle after reset release
      r_in_ready <= (w_next_state == S_IDLE);

      if (r_state == S_IDLE && w_accept) begin
        r_rd      <= w_rd;
        r_illegal <= (w_op == c_OP_ILL);
        case (w_op)
          c_OP_LDI: begin
            r_sel <= c_SEL_PASS;
            r_in1 <= w_imm;
            r_in2 <= '0;
          end
          c_OP_ILL: begin
            r_sel <= c_SEL_PASS;
            r_in1 <= '0;
            r_in2 <= '0;
          end
          default: begin
            r_sel <= {1'b0, w_op};
            r_in1 <= r_regs[w_rs1];
            r_in2 <= r_regs[w_rs2];
          end
        endcase
      end

      if (r_state == S_EXEC) begin
        r_out_rd    <= r_rd;
        r_out_valid <= 1'b1;
        if (r_illegal) begin
          r_out_data <= '0;
          r_out_err  <= 1'b1;
        end else begin
          r_regs[r_rd] <= alu_result;
          r_out_data   <= alu_result;
          r_out_err    <= 1'b0;
        end
      end else if (w_deliver) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready             = r_in_ready;
  assign out_valid            = r_out_valid;
  assign out_data             = r_out_data;
  assign out_rd               = r_out_rd;
  assign out_err              = r_out_err;
  assign alu_component_select = r_sel;
  assign alu_input_1          = r_in1;
  assign alu_input_2          = r_in2;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Self-checking bench for alu_issue_ctrl with a behavioural ALU and
//          a register-file reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  alu_component_select;
  logic [7:0]  alu_input_1;
  logic [7:0]  alu_input_2;
  logic [7:0]  alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_rd;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_regs [4];

  alu_issue_ctrl #(.DATA_W(8), .REG_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_component_select(alu_component_select),
    .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural downstream ALU
  always_comb begin
    case (alu_component_select)
      4'd0:    alu_result = alu_input_1 + alu_input_2;
      4'd1:    alu_result = alu_input_1 * alu_input_2;
      4'd2:    alu_result = alu_input_1 & alu_input_2;
      4'd3:    alu_result = alu_input_1 | alu_input_2;
      4'd4:    alu_result = ~alu_input_1;
      default: alu_result = alu_input_1;
    endcase
  end

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    mk = {op[2:0], rd[1:0], rs1[1:0], rs2[1:0], 7'b0};
  endfunction

  function automatic logic [15:0] mk_ldi(input int rd, input int imm);
    mk_ldi = {3'b101, rd[1:0], 3'b000, imm[7:0]};
  endfunction

  // Expected writeback value from the instruction semantics
  function automatic int ref_val(input int op, input int a, input int b, input int imm);
    case (op)
      0:       ref_val = (a + b) % 256;
      1:       ref_val = (a * b) % 256;
      2:       ref_val = a & b;
      3:       ref_val = a | b;
      4:       ref_val = 255 - a;
      5:       ref_val = imm;
      6:       ref_val = 0;
      default: ref_val = a;
    endcase
  endfunction

  // Issues one instruction, samples the ALU drive in EXEC, collects the response
  task automatic run_instr(input logic [15:0] ins, input int dly,
                           output logic [3:0] sel, output logic [7:0] a, output logic [7:0] b,
                           output logic [7:0] d, output logic [1:0] rd, output logic err,
                           output int lat, output bit ok);
    bit got;
    ok = 0; lat = -1; sel = 'x; a = 'x; b = 'x; d = 'x; rd = 'x; err = 1'bx;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) return;
    in_valid = 1'b1; in_instr = ins;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    sel = alu_component_select; a = alu_input_1; b = alu_input_2;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; lat = i; end
    end
    if (!got) return;
    repeat (dly) @(negedge clk);
    d = out_data; rd = out_rd; err = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    ok = 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if ({out_err, out_data, out_rd, alu_component_select, alu_input_1, alu_input_2} !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs got err=%b data=%h rd=%0d sel=%h in1=%h in2=%h want all 0",
               out_err, out_data, out_rd, alu_component_select, alu_input_1, alu_input_2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok;
    run_instr(mk_ldi(1, 8'h05), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'h05) begin bad++; $display("FAIL ldi_r1 got=%h ok=%0d want=05", d, ok); end
    run_instr(mk_ldi(2, 8'h03), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || s !== 4'b0111 || a !== 8'h03 || b !== 8'h00) begin
      bad++; $display("FAIL ldi_drive got sel=%h in1=%h in2=%h want 7/03/00", s, a, b); end
    run_instr(mk(0, 3, 1, 2), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || s !== 4'b0000 || a !== 8'h05 || b !== 8'h03) begin
      bad++; $display("FAIL add_drive got sel=%h in1=%h in2=%h want 0/05/03", s, a, b); end
    total++; if (d !== 8'h08 || r !== 2'd3 || e !== 1'b0) begin
      bad++; $display("FAIL add_resp got data=%h rd=%0d err=%b want 08/3/0", d, r, e); end
    total++; if (lat !== 0) begin bad++; $display("FAIL add_latency got=%0d want=0 extra cycles", lat); end
    m_regs[1] = 8'h05; m_regs[2] = 8'h03; m_regs[3] = 8'h08;
  endtask

  task automatic test_mult;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok;
    run_instr(mk_ldi(1, 8'h02), 0, s, a, b, d, r, e, lat, ok);
    run_instr(mk(1, 0, 1, 2), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'h06 || s !== 4'b0001) begin
      bad++; $display("FAIL mult_small got data=%h sel=%h want 06/1", d, s); end
    run_instr(mk_ldi(1, 8'h10), 0, s, a, b, d, r, e, lat, ok);
    run_instr(mk_ldi(2, 8'h20), 0, s, a, b, d, r, e, lat, ok);
    run_instr(mk(1, 0, 1, 2), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'h00 || r !== 2'd0) begin
      bad++; $display("FAIL mult_trunc got data=%h rd=%0d want 00/0", d, r); end
    m_regs[0] = 8'h00; m_regs[1] = 8'h10; m_regs[2] = 8'h20;
  endtask

  task automatic test_not_mov;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok;
    run_instr(mk_ldi(1, 8'h08), 0, s, a, b, d, r, e, lat, ok);
    run_instr(mk(4, 0, 1, 2), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || s !== 4'b0100 || d !== 8'hF7) begin
      bad++; $display("FAIL not got sel=%h data=%h want 4/F7", s, d); end
    run_instr(mk(7, 2, 0, 0), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'hF7 || r !== 2'd2) begin
      bad++; $display("FAIL mov got data=%h rd=%0d want F7/2", d, r); end
    m_regs[1] = 8'h08; m_regs[0] = 8'hF7; m_regs[2] = 8'hF7;
  endtask

  task automatic test_backpressure;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (in_ready) got = 1; end
    in_valid = 1'b1; in_instr = mk_ldi(2, 8'h77);
    @(posedge clk); #1 in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (out_valid) got = 1; end
    total++; if (!got) begin bad++; $display("FAIL bp_timeout got=no out_valid want out_valid"); end
    m_regs[2] = 8'h77;
    in_valid = 1'b1; in_instr = mk(7, 1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h77 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h in_ready=%b want 1/77/0",
                        i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || alu_component_select !== 4'b0111 || alu_input_1 !== 8'h77) begin
      bad++; $display("FAIL bp_accept got in_ready=%b sel=%h in1=%h want 0/7/77",
                      in_ready, alu_component_select, alu_input_1); end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (out_valid) got = 1; end
    total++; if (!got || out_data !== 8'h77 || out_rd !== 2'd1) begin
      bad++; $display("FAIL bp_next_resp got data=%h rd=%0d want 77/1", out_data, out_rd); end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    m_regs[1] = 8'h77;
  endtask

  task automatic test_illegal;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok;
    run_instr(mk_ldi(1, 8'h3C), 0, s, a, b, d, r, e, lat, ok);
    run_instr(mk(6, 1, 2, 3), 1, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || e !== 1'b1 || d !== 8'h00 || r !== 2'd1 || s !== 4'b0111 || a !== 8'h00) begin
      bad++; $display("FAIL illegal got err=%b data=%h rd=%0d sel=%h in1=%h want 1/00/1/7/00", e, d, r, s, a); end
    run_instr(mk(7, 0, 1, 0), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'h3C || e !== 1'b0) begin
      bad++; $display("FAIL illegal_nowrite got data=%h err=%b want 3C/0", d, e); end
    m_regs[1] = 8'h3C; m_regs[0] = 8'h3C;
  endtask

  task automatic test_reset_mid_exec;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok; bit got;
    run_instr(mk_ldi(3, 8'h5A), 0, s, a, b, d, r, e, lat, ok);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (in_ready) got = 1; end
    in_valid = 1'b1; in_instr = mk(0, 3, 1, 2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_err, out_data, out_rd, alu_component_select, alu_input_1, alu_input_2} !== 33'd0) begin
      bad++; $display("FAIL rst_async got in_ready=%b valid=%b err=%b data=%h sel=%h in1=%h want all 0",
                      in_ready, out_valid, out_err, out_data, alu_component_select, alu_input_1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_wb got valid=%b want 0", out_valid); end
    run_instr(mk(7, 0, 3, 0), 0, s, a, b, d, r, e, lat, ok);
    total++; if (!ok || d !== 8'h00) begin bad++; $display("FAIL rst_regs got r3=%h want 00", d); end
  endtask

  task automatic test_random;
    logic [3:0] s; logic [7:0] a, b, d; logic [1:0] r; logic e; int lat; bit ok;
    int op, rd, rs1, rs2, imm, ev, es, ea, eb;
    logic [15:0] ins;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7); rd = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3); imm = $urandom_range(0, 255);
      if (op == 5) begin
        ins = mk_ldi(rd, imm);
        rs2 = (imm >> 7) & 1;
      end else begin
        rs2 = $urandom_range(0, 3);
        ins = mk(op, rd, rs1, rs2);
        imm = ins[7:0];
      end
      ev = ref_val(op, m_regs[rs1], m_regs[rs2], imm);
      es = (op == 5 || op == 6) ? 7 : op;
      ea = (op == 5) ? imm : (op == 6) ? 0 : m_regs[rs1];
      eb = (op == 5 || op == 6) ? 0 : m_regs[rs2];
      run_instr(ins, $urandom_range(0, 3), s, a, b, d, r, e, lat, ok);
      total++;
      if (!ok || s !== 4'(es) || a !== 8'(ea) || b !== 8'(eb)) begin
        bad++; $display("FAIL rnd_drive n=%0d op=%0d got sel=%h in1=%h in2=%h want %h/%h/%h",
                        n, op, s, a, b, es, ea, eb);
      end
      total++;
      if (d !== 8'(ev) || r !== 2'(rd) || e !== (op == 6)) begin
        bad++; $display("FAIL rnd_resp n=%0d op=%0d got data=%h rd=%0d err=%b want %h/%0d/%0d",
                        n, op, d, r, e, ev, rd, op == 6);
      end
      if (op != 6) m_regs[rd] = 8'(ev);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mult;
    test_not_mov;
    test_backpressure;
    test_illegal;
    test_reset_mid_exec;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
